multi_push_seq: RTL and testbench

- Parametrised successor to the two-channel push/CRC sequencer.
- On `new_data`, pushes through `NUM_CH` channels in ascending order, one at a time, then runs a CRC phase.
- Reports completion with a registered `finish_strb`.
- Adds per-phase timeout with abort reporting and a busy flag. Sits between the packet ingress logic and the per-channel push engines.

---
 rtl/multi_push_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_multi_push_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_push_seq.sv
// multi_push_seq: on new_data, pushes NUM_CH channels in ascending order, then
// runs a CRC phase. Each phase has a timeout that aborts the sequence and
// reports the failing phase on err_ch. Optional macro CH_MASK_EN adds a ch_en
// port, latched at start, that selects which channels get pushed.
module multi_push_seq #(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64,
  parameter int unsigned TO_W            = 8,
  localparam int unsigned IDX_W          = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              new_data,
  input  logic [NUM_CH-1:0] push_done,
  input  logic              crc_done,
`ifdef CH_MASK_EN
  input  logic [NUM_CH-1:0] ch_en,
`endif
  output logic [NUM_CH-1:0] push_req,
  output logic [IDX_W-1:0]  ch_idx,
  output logic              crc_start,
  output logic              busy,
  output logic              finish_strb,
  output logic              abort_strb,
  output logic [IDX_W:0]    err_ch
);

  localparam int unsigned     ERR_W   = IDX_W + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PUSH = 2'd1,
    S_CRC  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]    ch_idx_q, ch_idx_d;
  logic [NUM_CH-1:0]   push_req_q, push_req_d;
  logic                crc_start_q, crc_start_d;
  logic                busy_q, busy_d;
  logic                finish_q, finish_d;
  logic                abort_q, abort_d;
  logic [ERR_W-1:0]    err_ch_q, err_ch_d;

  logic [NUM_CH-1:0]   start_mask;
  logic [NUM_CH-1:0]   run_mask;
  logic                first_found, nxt_found;
  logic [IDX_W-1:0]    first_idx, nxt_idx;
  logic                cur_done;
  logic                timeout;

`ifdef CH_MASK_EN
  logic [NUM_CH-1:0]   mask_q, mask_d;

  assign start_mask = ch_en;
  assign run_mask   = mask_q;

  // Channel mask latched when a sequence is accepted
  always_comb begin
    mask_d = mask_q;
    if (state_q == S_IDLE && new_data) begin
      mask_d = ch_en;
    end
  end

  // Mask register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end
`else
  assign start_mask = '1;
  assign run_mask   = '1;
`endif

  assign cur_done = push_done[ch_idx_q];
  assign timeout  = (cnt_q == TO_LAST);

  // Lowest enabled channel at start, and next enabled channel above ch_idx
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    nxt_found   = 1'b0;
    nxt_idx     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (start_mask[i]) begin
        first_found = 1'b1;
        first_idx   = IDX_W'(i);
      end
      if (run_mask[i] && (IDX_W'(i) > ch_idx_q)) begin
        nxt_found = 1'b1;
        nxt_idx   = IDX_W'(i);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; completion takes priority over timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (new_data) begin
          state_d = first_found ? S_PUSH : S_CRC;
        end
      end
      S_PUSH: begin
        if (cur_done) begin
          state_d = nxt_found ? S_PUSH : S_CRC;
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      S_CRC: begin
        if (crc_done || timeout) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and counter next values, registered below
  always_comb begin
    cnt_d       = cnt_q;
    ch_idx_d    = ch_idx_q;
    err_ch_d    = err_ch_q;
    push_req_d  = '0;
    crc_start_d = 1'b0;
    finish_d    = 1'b0;
    abort_d     = 1'b0;
    busy_d      = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (new_data) begin
          cnt_d    = '0;
          err_ch_d = '0;
          if (first_found) begin
            ch_idx_d             = first_idx;
            push_req_d[first_idx] = 1'b1;
          end else begin
            crc_start_d = 1'b1;
          end
        end
      end
      S_PUSH: begin
        if (cur_done) begin
          cnt_d = '0;
          if (nxt_found) begin
            ch_idx_d            = nxt_idx;
            push_req_d[nxt_idx] = 1'b1;
          end else begin
            crc_start_d = 1'b1;
          end
        end else if (timeout) begin
          cnt_d    = '0;
          abort_d  = 1'b1;
          err_ch_d = ERR_W'(ch_idx_q);
        end else begin
          cnt_d                = cnt_q + TO_W'(1);
          push_req_d[ch_idx_q] = 1'b1;
        end
      end
      S_CRC: begin
        if (crc_done) begin
          cnt_d    = '0;
          finish_d = 1'b1;
        end else if (timeout) begin
          cnt_d    = '0;
          abort_d  = 1'b1;
          err_ch_d = ERR_W'(NUM_CH);
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q       <= '0;
      ch_idx_q    <= '0;
      push_req_q  <= '0;
      crc_start_q <= 1'b0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
      abort_q     <= 1'b0;
      err_ch_q    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      ch_idx_q    <= ch_idx_d;
      push_req_q  <= push_req_d;
      crc_start_q <= crc_start_d;
      busy_q      <= busy_d;
      finish_q    <= finish_d;
      abort_q     <= abort_d;
      err_ch_q    <= err_ch_d;
    end
  end

  assign push_req    = push_req_q;
  assign ch_idx      = ch_idx_q;
  assign crc_start   = crc_start_q;
  assign busy        = busy_q;
  assign finish_strb = finish_q;
  assign abort_strb  = abort_q;
  assign err_ch      = err_ch_q;

endmodule

// File: tb/tb_multi_push_seq.sv
// Bench for multi_push_seq (NUM_CH=4, TIMEOUT_CYCLES=8): randomized engine
// delays, an event-level reference model feeding a scoreboard queue, and a
// monitor that turns DUT outputs into events and compares them.
module tb_multi_push_seq;

  localparam int NCH  = 4;
  localparam int TO   = 8;
  localparam int NSEQ = 60;

  logic       clk = 1'b0;
  logic       rstn;
  logic       new_data;
  logic [3:0] push_done;
  logic       crc_done;
  logic [3:0] push_req;
  logic [1:0] ch_idx;
  logic       crc_start;
  logic       busy;
  logic       finish_strb;
  logic       abort_strb;
  logic [2:0] err_ch;

  always #5 clk = ~clk;

  multi_push_seq #(
    .NUM_CH        (NCH),
    .TIMEOUT_CYCLES(TO),
    .TO_W          (8)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .new_data   (new_data),
    .push_done  (push_done),
    .crc_done   (crc_done),
`ifdef CH_MASK_EN
    .ch_en      (4'hF),
`endif
    .push_req   (push_req),
    .ch_idx     (ch_idx),
    .crc_start  (crc_start),
    .busy       (busy),
    .finish_strb(finish_strb),
    .abort_strb (abort_strb),
    .err_ch     (err_ch)
  );

  // kind: 0 push segment (ch*256+len), 1 crc_start, 2 finish (busy cycles), 3 abort (err_ch)
  typedef struct {
    int kind;
    int val;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  int         d_cfg[NCH];
  int         dc_cfg;
  int         wcnt, ccnt;
  logic [3:0] last_req;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: expected event stream of one sequence from its delays
  task automatic model_seq();
    int  total;
    bit  aborted;
    total   = 0;
    aborted = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      int len;
      len = (d_cfg[i] < TO) ? d_cfg[i] : TO;
      exp_q.push_back('{0, i * 256 + len});
      total += len;
      if (d_cfg[i] > TO) begin
        exp_q.push_back('{3, i});
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      exp_q.push_back('{1, 0});
      if (dc_cfg <= TO) exp_q.push_back('{2, total + dc_cfg});
      else              exp_q.push_back('{3, NCH});
    end
  endtask

  task automatic set_seq(input int a, input int b, input int c, input int d, input int dc);
    d_cfg[0] = a; d_cfg[1] = b; d_cfg[2] = c; d_cfg[3] = d;
    dc_cfg   = dc;
    wcnt     = 0;
    ccnt     = 0;
    last_req = '0;
  endtask

  // Engines: done after d cycles of request; other push_done bits are noise
  task automatic drive_resp();
    logic [3:0] pd;
    pd       = 4'($urandom) & ~push_req;
    crc_done = 1'b0;
    if (push_req != 4'b0000) begin
      if (push_req != last_req) wcnt = 0;
      wcnt++;
      if (wcnt == d_cfg[ch_idx]) pd = pd | push_req;
    end else if (busy) begin
      ccnt++;
      if (ccnt == dc_cfg) crc_done = 1'b1;
    end
    last_req  = push_req;
    push_done = pd;
  endtask

  function automatic int rnd_delay();
    int r;
    r = int'($urandom_range(0, 11));
    if (r == 0) return int'($urandom_range(9, 12));
    if (r == 1) return TO;
    return int'($urandom_range(1, 4));
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    int idx;
    idx = -1;
    for (int i = 0; i < NCH; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  task automatic emit(input int kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event actual=kind%0d/%0d expected=none at %0t", kind, val, $time);
    end else begin
      e = exp_q.pop_front();
      chk("event", kind * 4096 + val, e.kind * 4096 + e.val);
    end
  endtask

  // Monitor: converts DUT outputs into events for the scoreboard
  logic [3:0] cur_req;
  int         seg_len;
  int         bcnt;
  always @(negedge clk) begin
    if (!mon_en) begin
      cur_req = '0;
      seg_len = 0;
      bcnt    = 0;
    end else begin
      if (push_req != 4'b0000) chk("push_onehot", int'(push_req), int'(1) << ch_idx);
      if (push_req != cur_req) begin
        if (cur_req != 4'b0000) emit(0, onehot_idx(cur_req) * 256 + seg_len);
        cur_req = push_req;
        seg_len = (push_req != 4'b0000) ? 1 : 0;
      end else if (push_req != 4'b0000) begin
        seg_len++;
      end
      if (busy) begin
        bcnt++;
        chk("err_ch_busy", int'(err_ch), 0);
      end
      if (crc_start) emit(1, 0);
      if (finish_strb || abort_strb)
        chk("strobe_state", int'({busy, finish_strb & abort_strb}), 0);
      if (finish_strb) begin
        emit(2, bcnt);
        bcnt = 0;
      end
      if (abort_strb) begin
        emit(3, int'(err_ch));
        bcnt = 0;
      end
    end
  end

  initial begin
    bit fin;
    bit hit;
    rstn      = 1'b0;
    new_data  = 1'b1;
    push_done = '0;
    crc_done  = 1'b0;
    set_seq(1, 1, 1, 1, 1);

    // Reset held with new_data high
    repeat (3) @(negedge clk);
    chk("rst_push_req", int'(push_req), 0);
    chk("rst_ch_idx", int'(ch_idx), 0);
    chk("rst_crc_start", int'(crc_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_finish", int'(finish_strb), 0);
    chk("rst_abort", int'(abort_strb), 0);
    chk("rst_err_ch", int'(err_ch), 0);
    new_data = 1'b0;
    rstn     = 1'b1;
    mon_en   = 1'b1;
    @(negedge clk);

    // Sequences issued back-to-back: next new_data lands on the strobe cycle
    for (int s = 0; s < NSEQ; s++) begin
      case (s)
        0:       set_seq(1, 1, 1, 1, 1);
        1:       set_seq(1, 20, 1, 1, 1);
        2:       set_seq(1, 1, 1, 1, 20);
        3:       set_seq(2, 1, 3, 1, TO);
        4:       set_seq(1, 2, TO, 1, 2);
        5:       set_seq(TO + 1, 1, 1, 1, 1);
        6:       set_seq(1, 1, 1, 20, 1);
        default: set_seq(rnd_delay(), rnd_delay(), rnd_delay(), rnd_delay(), rnd_delay());
      endcase
      model_seq();
      new_data = 1'b1;
      fin      = 1'b0;
      for (int g = 0; g < 200 && !fin; g++) begin
        @(negedge clk);
        new_data = busy & 1'($urandom);
        drive_resp();
        if (finish_strb || abort_strb) fin = 1'b1;
      end
      if (!fin) chk("seq_timeout", 0, 1);
    end
    new_data = 1'b0;
    repeat (3) begin
      @(negedge clk);
      drive_resp();
    end
    chk("queue_drain", exp_q.size(), 0);

    // Reset in the middle of PUSH at ch_idx 2
    mon_en = 1'b0;
    set_seq(3, 3, 3, 3, 1);
    new_data = 1'b1;
    hit      = 1'b0;
    for (int g = 0; g < 50 && !hit; g++) begin
      @(negedge clk);
      new_data = 1'b0;
      drive_resp();
      if (ch_idx == 2'd2 && push_req == 4'b0100) hit = 1'b1;
    end
    chk("reach_ch2", int'(hit), 1);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_push_req", int'(push_req), 0);
    chk("midrst_ch_idx", int'(ch_idx), 0);
    chk("midrst_strobes", int'({finish_strb, abort_strb, crc_start}), 0);
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", int'({busy, finish_strb, abort_strb}), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
